alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU: successor to the single-cycle registered 4-opcode ALU.
- Adds configurable data width, extended opcode set, carry/zero/error flags, and valid/ready handshakes on input and output with full backpressure.
- Sits between the operand issue logic and the result consumer; sustains one operation per clock when not stalled.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).
- OPW, 3, opcode width; fixed at 3 in this generation, anything else is a lint/elab error.

Ports:
- clk  input  1  single clock, all state on posedge.
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands this cycle.
- opcode  input  OPW  operation select.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result this cycle.
- C  output  WIDTH  result.
- carry  output  1  add carry-out / sub borrow; 0 for other opcodes.
- zero  output  1  C == 0.
- err  output  1  reserved opcode was issued.

Behaviour:
- Reset (reset==0, async): s1_valid=0, s2_valid=0, out_valid=0, C=0, carry=0, zero=0, err=0. in_ready=1 from the first clock after release. In-flight operations are dropped, never emitted.
- Handshake: accept on in_valid&&in_ready; emit on out_valid&&out_ready. Inputs are sampled only on accept. Outputs hold stable while out_valid&&!out_ready.
- Stage 1 registers opcode/A/B. Stage 2 registers C and flags computed from stage 1.
- Advance rules: s2 loads when !s2_valid || out_ready. s1 advances into s2 when s1_valid && s2 loads. in_ready = !s1_valid || (s1 advances this cycle), with no combinational path from in_valid.
- Latency: exactly 2 clocks from accept to out_valid when unstalled. Throughput: 1/clk.
- Capacity: 2 operations max in flight. A third offer is held off (in_ready=0) until out_ready frees a slot.
- Order: strictly in order; no loss, no duplication.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 0: C=A+B; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 1: C=A-B; carry = borrow (1 iff A<B unsigned).
  - 2: C=~A.
  - 3: C={WIDTH-1 zeros, |B}.
  - 4: C=A&B.
  - 5: C=A|B.
  - 6: C=A^B.
  - 7: reserved; C=0, err=1.
- zero is derived from the final C. err is 0 for opcodes 0-6.
- Simultaneous accept and emit with both stages full: legal. s2 takes s1, s1 takes new input.
- Reset asserted mid-stall: out_valid falls asynchronously; the consumer must not see the held result again.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined:
  - Opcodes 0/1 treat A/B as two's-complement signed and saturate to 2^(WIDTH-1)-1 or -2^(WIDTH-1) on overflow.
  - Extra output port sat (1 bit, reset 0) is high for a result that saturated.
  - carry still reports the raw unsigned carry/borrow.
- Undefined: wrap-around arithmetic only; no sat port.

Test Plan:
- WIDTH=8, reset released, opcode 0, A=8'hF0, B=8'h20, out_ready=1 -> accepted cycle 0, out_valid cycle 2, C=8'h10, carry=1, zero=0, err=0.
- opcode 1, A=8'h05, B=8'h07 -> C=8'hFE, carry=1. Then opcode 1, A=8'h07, B=8'h07 -> C=8'h00, carry=0, zero=1.
- opcode 3 with B=8'h00 then B=8'h40, back-to-back -> C=8'h00 (zero=1), then C=8'h01. out_valid on consecutive cycles.
- out_ready=0 for 4 cycles while offering ops 2,4,6 (A=8'h0F, B=8'h3C) -> first two accepted, in_ready=0 on the third until out_ready=1. Results in order: 8'hF0, 8'h0C, 8'h33.
- opcode 7, A=8'hFF, B=8'hFF -> C=8'h00, zero=1, err=1, carry=0.
- Two ops in flight, reset pulled low mid-cycle -> out_valid, C and flags 0 before the next clk edge. After release, nothing emitted until a new accept.
- With ALU_PIPE_SAT_EN: opcode 0, A=8'h70, B=8'h20 -> C=8'h7F, sat=1. Opcode 1, A=8'h80, B=8'h01 -> C=8'h80, sat=1.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Two-stage pipelined ALU with valid/ready handshakes on both
//            sides and full backpressure. Stage 1 captures opcode/operands,
//            and stage 2 captures the result and flags.
//            Sustains one operation per clock and holds at most two
//            operations in flight.
// Ports    : clk, reset (async active-low)
//            in_valid / in_ready / opcode / A / B      - operand side
//            out_valid / out_ready / C / carry / zero / err - result side
//            sat (only with ALU_PIPE_SAT_EN)          - result was saturated
// Options  : ALU_PIPE_SAT_EN - signed saturating add/sub (opcodes 0/1)
//            and an extra 'sat' output port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             carry,
    output logic             zero,
    output logic             err
`ifdef ALU_PIPE_SAT_EN
    ,
    output logic             sat
`endif
);

    // Opcode encoding
    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_SUB  = 3'd1;
    localparam logic [2:0] c_OP_NOT  = 3'd2;
    localparam logic [2:0] c_OP_ORB  = 3'd3;
    localparam logic [2:0] c_OP_AND  = 3'd4;
    localparam logic [2:0] c_OP_OR   = 3'd5;
    localparam logic [2:0] c_OP_XOR  = 3'd6;

    // Elaboration-time guards on the parameter ranges
    generate
        if (OPW != 3) begin : g_opw_check
            $error("alu_pipe: OPW must be 3");
        end
        if (WIDTH < 2) begin : g_width_check
            $error("alu_pipe: WIDTH must be at least 2");
        end
    endgenerate

    // Stage 1 registers
    logic             r_s1_valid;
    logic [OPW-1:0]   r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    // Stage 2 registers (drive the outputs directly)
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_c;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;

    // Pipeline control
    logic w_s2_load;
    logic w_s1_adv;
    logic w_accept;

    // Stage-2 next values
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_c;
    logic             w_carry;
    logic             w_err;

    // Stage 2 can take new data when empty or when its result is leaving.
    // in_ready depends only on registered state and out_ready, never on
    // in_valid.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_load;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_accept  = in_valid && in_ready;

    // Extended by one bit: bit WIDTH is the carry-out for the add and
    // the borrow for the subtract.
    assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};

`ifdef ALU_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] c_SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_add_ovf;
    logic w_sub_ovf;
    logic w_sat;
    logic r_sat;

    // Signed overflow: the operand signs allow it and the result sign
    // disagrees with A. On overflow the true result has the same sign as A,
    // so the sign of A picks the clamp value.
    assign w_add_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
    assign w_sub_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
`endif

    always_comb begin
        w_c     = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
`ifdef ALU_PIPE_SAT_EN
        w_sat   = 1'b0;
`endif
        case (r_s1_op)
            c_OP_ADD: begin
                w_c     = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                if (w_add_ovf) begin
                    w_c   = r_s1_a[WIDTH-1] ? c_SMIN : c_SMAX;
                    w_sat = 1'b1;
                end
`endif
            end
            c_OP_SUB: begin
                w_c     = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                if (w_sub_ovf) begin
                    w_c   = r_s1_a[WIDTH-1] ? c_SMIN : c_SMAX;
                    w_sat = 1'b1;
                end
`endif
            end
            c_OP_NOT: w_c = ~r_s1_a;
            c_OP_ORB: w_c = {{(WIDTH-1){1'b0}}, |r_s1_b};
            c_OP_AND: w_c = r_s1_a & r_s1_b;
            c_OP_OR:  w_c = r_s1_a | r_s1_b;
            c_OP_XOR: w_c = r_s1_a ^ r_s1_b;
            default:  w_err = 1'b1;   // reserved opcode: C stays 0
        endcase
    end

    // Stage 1: operands are captured only on accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= opcode;
            r_s1_a     <= A;
            r_s1_b     <= B;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: the result holds while stalled. When it loads with stage 1
    // empty, only the valid bit drops and the old data is left untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_c        <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_c     <= w_c;
                r_carry <= w_carry;
                r_zero  <= (w_c == '0);
                r_err   <= w_err;
            end
        end
    end

`ifdef ALU_PIPE_SAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat <= 1'b0;
        end else if (w_s2_load && r_s1_valid) begin
            r_sat <= w_sat;
        end
    end

    assign sat = r_sat;
`endif

    assign out_valid = r_s2_valid;
    assign C         = r_c;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign err       = r_err;

endmodule
`default_nettype wire
